// File: rtl/frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : frame_loader
// Description : Streams 12-bit RGB pixels into a frame buffer, one write per
//               accepted beat, framed by start-of-frame markers.
//               Optional checksum enabled by macro FRAME_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_loader #(
    parameter int IMG_PIXELS = 120000,
    parameter int ADDR_W     = 18
) (
    input  logic              clk_40,
    input  logic              reset,
    input  logic [11:0]       s_pixel,
    input  logic              s_valid,
    input  logic              s_sof,
    output logic              s_ready,
    input  logic              wr_hold,
    input  logic              err_clr,
    output logic              wea,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [3:0]        dina_r,
    output logic [3:0]        dina_g,
    output logic [3:0]        dina_b,
    output logic              busy,
    output logic              frame_done,
    output logic              sync_err,
    output logic [15:0]       checksum
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_LOAD = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(IMG_PIXELS - 1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_count;

    logic                w_accept;
    logic                w_write;
    logic                w_last;
    logic [ADDR_W-1:0]   w_addr;
    logic [ADDR_W-1:0]   w_next_count;

    assign s_ready  = !wr_hold && !reset;
    assign w_accept = s_valid && s_ready;

    // A start-of-frame beat always lands at address 0, regardless of state;
    // non-sof beats are only meaningful once a frame has been opened.
    assign w_write      = w_accept && ((r_state == S_LOAD) || s_sof);
    assign w_addr       = s_sof ? '0 : r_count;
    assign w_last       = (w_addr == C_LAST_ADDR);
    assign w_next_count = w_last ? '0 : (w_addr + ADDR_W'(1));

    assign busy = (r_state == S_LOAD);

    always_ff @(posedge clk_40) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            wea        <= 1'b0;
            wr_addr    <= '0;
            dina_r     <= 4'd0;
            dina_g     <= 4'd0;
            dina_b     <= 4'd0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            wea        <= w_write;
            frame_done <= w_write && w_last;
            if (w_write) begin
                wr_addr <= w_addr;
                dina_r  <= s_pixel[11:8];
                dina_g  <= s_pixel[7:4];
                dina_b  <= s_pixel[3:0];
                r_count <= w_next_count;
                r_state <= w_last ? S_IDLE : S_LOAD;
            end
            // A fresh framing error takes priority over a simultaneous clear.
            if (w_accept && s_sof && (r_state == S_LOAD)) begin
                sync_err <= 1'b1;
            end else if (err_clr) begin
                sync_err <= 1'b0;
            end
        end
    end

`ifdef FRAME_LOADER_CHECKSUM_EN
    logic [15:0] r_acc;
    logic [15:0] r_checksum;
    logic [15:0] w_sum;

    assign w_sum    = (s_sof ? 16'd0 : r_acc) + {4'd0, s_pixel};
    assign checksum = r_checksum;

    always_ff @(posedge clk_40) begin
        if (reset) begin
            r_acc      <= 16'd0;
            r_checksum <= 16'd0;
        end else if (w_write) begin
            r_acc <= w_sum;
            if (w_last) begin
                r_checksum <= w_sum;
            end
        end
    end
`else
    assign checksum = 16'd0;
`endif

endmodule
`default_nettype wire
